// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_scan
// Brief    : Keypad row scanner and debouncer. Walks the row select through
//            rows 0..2 and samples the key decoder once per row. It resolves
//            one key per scan frame and commits a change after DEBOUNCE_CNT
//            identical frames.
// Revision : 1.0 - initial release
// ============================================================================
module key_scan #(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press,
  input  logic [3:0] scan_code,
  output logic [2:0] sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                STAB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CNT);
  localparam logic [3:0]        NONE     = 4'hF;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_WAIT  = 2'd1,
    HELD        = 2'd2,
    CHANGE_WAIT = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div;
  logic                captured;
  logic [3:0]          frame_code;
  logic [3:0]          cand, cand_n;
  logic [STAB_W-1:0]   stab, stab_n;
  logic                sample, frame_end, commit, valid_n;
  logic [3:0]          res;

  // Sample point is the last dwell cycle of each row; frame ends on row 2.
  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (sel == 3'd2);
  // The last row's own sample still counts toward this frame's result.
  assign res       = (sample && press && !captured) ? scan_code : frame_code;

  // Row divider and row select: advance the row after its sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      sel <= 3'd0;
    end else if (sample) begin
      div <= '0;
      sel <= (sel == 3'd2) ? 3'd0 : sel + 3'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // First pressed row of the frame wins; cleared when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured   <= 1'b0;
      frame_code <= NONE;
    end else if (frame_end) begin
      captured   <= 1'b0;
      frame_code <= NONE;
    end else if (sample && press && !captured) begin
      captured   <= 1'b1;
      frame_code <= scan_code;
    end
  end

  // Candidate tracking: count consecutive identical frame results.
  always_comb begin
    cand_n = cand;
    stab_n = stab;
    if (frame_end) begin
      if (res == cand) begin
        stab_n = (stab == STAB_MAX) ? stab : stab + STAB_W'(1);
      end else begin
        cand_n = res;
        stab_n = STAB_W'(1);
      end
    end
  end

  assign commit = frame_end && (stab_n == STAB_MAX) && (cand_n != key_code);

  // Candidate and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= NONE;
      stab <= '0;
    end else begin
      cand <= cand_n;
      stab <= stab_n;
    end
  end

  // Key FSM next state; a commit that lands in HELD is a new key press.
  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (frame_end && res != NONE)
          state_n = commit ? HELD : PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (commit)
          state_n = HELD;
        else if (frame_end && res == NONE)
          state_n = IDLE;
      end
      HELD: begin
        if (frame_end && res != key_code) begin
          if (commit)
            state_n = (cand_n == NONE) ? IDLE : HELD;
          else
            state_n = CHANGE_WAIT;
        end
      end
      CHANGE_WAIT: begin
        if (commit)
          state_n = (cand_n == NONE) ? IDLE : HELD;
        else if (frame_end && res == key_code)
          state_n = HELD;
      end
      default: state_n = IDLE;
    endcase
    valid_n = commit && (state_n == HELD);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Registered outputs: committed key, held level and one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= NONE;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= valid_n;
      if (commit) begin
        key_code <= cand_n;
        key_held <= (cand_n != NONE);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scan
// Brief    : Self-checking bench for key_scan (SCAN_DIV=4, DEBOUNCE_CNT=3).
//            A behavioural keypad decoder maps key c to row c/3. The lowest
//            pressed code on the selected row is reported.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 3 * SD;

  localparam logic [15:0] K2 = 16'h0004;
  localparam logic [15:0] K4 = 16'h0010;
  localparam logic [15:0] K6 = 16'h0040;
  localparam logic [15:0] K8 = 16'h0100;
  localparam logic [3:0]  KF = 4'hF;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    logic        held;
    logic        valid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       press;
  logic [3:0] scan_code;
  logic [2:0] sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  logic        started = 1'b0;
  int          cyc;
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        sb[$];
  vec_t        tbl[64];
  int          ntbl = 0;

  key_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .scan_code(scan_code),
    .sel(sel), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Behavioural decoder: lowest pressed code on the selected row.
  always_comb begin
    press     = 1'b0;
    scan_code = KF;
    for (int c = 8; c >= 0; c--) begin
      if (keys[c] && (c / 3) == int'(sel)) begin
        press     = 1'b1;
        scan_code = c[3:0];
      end
    end
  end

  // Cycle index since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: row sequence every cycle, scoreboard pop after every frame end.
  always @(negedge clk) begin
    if (rst_n && started) begin
      check("sel_seq", 32'(sel), 32'((cyc / SD) % 3));
      if (cyc > 0 && (cyc % FRAME) == 0) begin
        if (sb.size() > 0) begin
          vec_t e;
          e = sb.pop_front();
          check("key_code", 32'(key_code), 32'(e.code));
          check("key_held", 32'(key_held), 32'(e.held));
          check("key_valid", 32'(key_valid), 32'(e.valid));
        end
      end else begin
        check("no_pulse", 32'(key_valid), 32'd0);
      end
    end
  end

  task automatic add(input logic [15:0] k, input logic [3:0] c, input logic h,
                     input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      tbl[ntbl] = '{keys: k, code: c, held: h, valid: v};
      ntbl++;
    end
  endtask

  task automatic run_frame(input logic [15:0] k, input logic [3:0] c, input logic h,
                           input logic v);
    keys = k;
    sb.push_back('{keys: k, code: c, held: h, valid: v});
    repeat (FRAME) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_code"}, 32'(key_code), 32'hF);
    check({tag, "_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_held"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    // Per-frame stimulus and the outputs expected after that frame's end.
    add(K2,      KF,   1'b0, 1'b0, 2);
    add(K2,      4'h2, 1'b1, 1'b1, 1);
    add(K2,      4'h2, 1'b1, 1'b0, 10);
    add(K4,      4'h2, 1'b1, 1'b0, 2);
    add(K4,      4'h4, 1'b1, 1'b1, 1);
    add(K4,      4'h4, 1'b1, 1'b0, 1);
    add(K6,      4'h4, 1'b1, 1'b0, 2);
    add(K6,      4'h6, 1'b1, 1'b1, 1);
    add(K6,      4'h6, 1'b1, 1'b0, 1);
    add('0,      4'h6, 1'b1, 1'b0, 2);
    add('0,      KF,   1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      add(K4,    KF,   1'b0, 1'b0, 1);
      add('0,    KF,   1'b0, 1'b0, 1);
    end
    add(K2 | K8, KF,   1'b0, 1'b0, 2);
    add(K2 | K8, 4'h2, 1'b1, 1'b1, 1);
    add(K2 | K8, 4'h2, 1'b1, 1'b0, 1);
    add(K8,      4'h2, 1'b1, 1'b0, 2);
    add(K8,      4'h8, 1'b1, 1'b1, 1);
    add(K4 | K6, 4'h8, 1'b1, 1'b0, 2);
    add(K4 | K6, 4'h4, 1'b1, 1'b1, 1);
    add(K6,      4'h4, 1'b1, 1'b0, 1);
    add(K4,      4'h4, 1'b1, 1'b0, 3);
    add('0,      4'h4, 1'b1, 1'b0, 2);
    add('0,      KF,   1'b0, 1'b0, 1);

    // Reset state while held.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    started = 1'b1;

    for (int i = 0; i < ntbl; i++)
      run_frame(tbl[i].keys, tbl[i].code, tbl[i].held, tbl[i].valid);

    // Key arriving after its row's sample cycle does not count that frame.
    keys = '0;
    sb.push_back('{keys: K2, code: KF, held: 1'b0, valid: 1'b0});
    repeat (SD) @(posedge clk);
    #1;
    keys = K2;
    repeat (FRAME - SD) @(posedge clk);
    #1;
    run_frame(K2, KF,   1'b0, 1'b0);
    run_frame(K2, KF,   1'b0, 1'b0);
    run_frame(K2, 4'h2, 1'b1, 1'b1);
    run_frame('0, 4'h2, 1'b1, 1'b0);
    run_frame('0, 4'h2, 1'b1, 1'b0);
    run_frame('0, KF,   1'b0, 1'b0);

    // Asynchronous reset in PRESS_WAIT with two stable frames behind it.
    run_frame(K2, KF, 1'b0, 1'b0);
    run_frame(K2, KF, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_frame(K2, KF,   1'b0, 1'b0);
    run_frame(K2, KF,   1'b0, 1'b0);
    run_frame(K2, 4'h2, 1'b1, 1'b1);
    run_frame(K2, 4'h2, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
